// File: rtl/grn_attractor_ctrl.sv
// Sequencer for a bank of two-phase Boolean-network nodes: loads an initial state,
// finds an attractor with tortoise/hare stepping, then measures its period.
module grn_attractor_ctrl #(
  parameter int unsigned N_NODES   = 8,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_NODES-1:0]  init_vec,
  input  logic [N_NODES-1:0]  s0_vec,
  input  logic [N_NODES-1:0]  s1_vec,
  output logic                reset_nos,
  output logic [N_NODES-1:0]  init_state,
  output logic                start_s0,
  output logic                start_s1,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [STEP_W-1:0]   meet_step,
  output logic [STEP_W-1:0]   period,
  output logic [N_NODES-1:0]  attractor
);

  typedef enum logic [2:0] {StIdle, StLoad, StFind, StPeriod, StDone} state_e;

  localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]    per_q, per_d;
  logic [STEP_W-1:0]    meet_q, meet_d;
  logic [STEP_W-1:0]    period_q, period_d;
  logic [N_NODES-1:0]   attr_q, attr_d;
  logic [N_NODES-1:0]   init_q, init_d;
  logic                 timeout_q, timeout_d;
  logic                 find_match, per_match;

  // Hare and tortoise are only comparable on even steps, when both have moved.
  assign find_match = !step_q[0] && (step_q >= STEP_W'(2)) && (s0_vec == s1_vec);
  assign per_match  = (per_q != '0) && (s1_vec == attr_q);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    per_d     = per_q;
    meet_d    = meet_q;
    period_d  = period_q;
    attr_d    = attr_q;
    init_d    = init_q;
    timeout_d = timeout_q;
    reset_nos = 1'b0;
    start_s0  = 1'b0;
    start_s1  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            init_d  = init_vec;
            state_d = StLoad;
          end
        end
        StLoad: begin
          reset_nos = 1'b1;
          step_d    = '0;
          per_d     = '0;
          timeout_d = 1'b0;
          state_d   = StFind;
        end
        StFind: begin
          if (find_match) begin
            meet_d  = step_q;
            attr_d  = s1_vec;
            per_d   = '0;
            state_d = StPeriod;
          end else if (step_q == MaxSteps) begin
            timeout_d = 1'b1;
            meet_d    = step_q;
            state_d   = StDone;
          end else begin
            start_s0 = 1'b1;
            start_s1 = 1'b1;
            step_d   = step_q + STEP_W'(1);
          end
        end
        StPeriod: begin
          if (per_match) begin
            period_d = per_q;
            state_d  = StDone;
          end else if (per_q == MaxSteps) begin
            timeout_d = 1'b1;
            period_d  = per_q;
            state_d   = StDone;
          end else begin
            start_s1 = 1'b1;
            per_d    = per_q + STEP_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      per_q     <= '0;
      meet_q    <= '0;
      period_q  <= '0;
      attr_q    <= '0;
      init_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      per_q     <= per_d;
      meet_q    <= meet_d;
      period_q  <= period_d;
      attr_q    <= attr_d;
      init_q    <= init_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy       = (state_q == StLoad) || (state_q == StFind) || (state_q == StPeriod);
  assign done       = (state_q == StDone);
  assign timeout    = timeout_q;
  assign meet_step  = meet_q;
  assign period     = period_q;
  assign attractor  = attr_q;
  assign init_state = init_q;

endmodule
